// File: rtl/imm_decode_buffer.sv
// Decode front end: 2-entry skid buffer that pre-decodes the immediate-extender select.
// Optional IMM_ILLEGAL_EN macro adds per-entry illegal-opcode flag on out_illegal.
module imm_decode_buffer #(
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [PC_W-1:0] out_pc,
  output logic [24:0]     out_imm_field,
  output logic [2:0]      out_imm_src,
  output logic            out_illegal
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  typedef struct packed {
    logic [31:0]     instr;
    logic [PC_W-1:0] pc;
    logic [2:0]      src;
  } entry_t;

  function automatic logic [2:0] imm_src(input logic [6:0] op);
    case (op)
      7'b0000011, 7'b0010011, 7'b1100111: imm_src = 3'b000;
      7'b0100011:                         imm_src = 3'b001;
      7'b1100011:                         imm_src = 3'b010;
      7'b0110111, 7'b0010111:             imm_src = 3'b011;
      7'b1101111:                         imm_src = 3'b100;
      7'b1110011:                         imm_src = 3'b101;
      default:                            imm_src = 3'b111;
    endcase
  endfunction

  state_t state_q, state_d;
  entry_t head_q, tail_q, in_ent;
  logic   acc, pop;
  logic   head_ld_in, head_ld_tail, tail_ld;
  logic   in_ready_d, out_valid_d;

  assign acc    = in_valid & in_ready;
  assign pop    = out_valid & out_ready;
  assign in_ent = '{instr: in_instr, pc: in_pc, src: imm_src(in_instr[6:0])};

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
    end
  end

  // next-state
  always_comb begin
    state_d = state_q;
    if (flush) state_d = EMPTY;
    else begin
      case (state_q)
        EMPTY: if (acc) state_d = ONE;
        ONE: begin
          if (acc && !pop)      state_d = FULL;
          else if (pop && !acc) state_d = EMPTY;
        end
        FULL:    if (pop) state_d = ONE;
        default: state_d = EMPTY;
      endcase
    end
  end

  // outputs: handshake flags are registered copies of the next occupancy
  always_comb begin
    in_ready_d   = (state_d != FULL);
    out_valid_d  = (state_d != EMPTY);
    head_ld_in   = !flush && acc && (state_q == EMPTY || (state_q == ONE && pop));
    tail_ld      = !flush && acc && state_q == ONE && !pop;
    head_ld_tail = !flush && pop && state_q == FULL;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q <= '{instr: '0, pc: '0, src: 3'b111};
      tail_q <= '{instr: '0, pc: '0, src: 3'b111};
    end else begin
      if (head_ld_in)        head_q <= in_ent;
      else if (head_ld_tail) head_q <= tail_q;
      if (tail_ld)           tail_q <= in_ent;
    end
  end

  assign out_instr     = head_q.instr;
  assign out_pc        = head_q.pc;
  assign out_imm_field = head_q.instr[31:7];
  assign out_imm_src   = head_q.src;

`ifdef IMM_ILLEGAL_EN
  function automatic logic is_illegal(input logic [6:0] op);
    case (op)
      7'b0000011, 7'b0010011, 7'b1100111, 7'b0100011, 7'b1100011,
      7'b0110111, 7'b0010111, 7'b1101111, 7'b1110011, 7'b0110011:
               is_illegal = 1'b0;
      default: is_illegal = 1'b1;
    endcase
  endfunction

  logic head_ill_q, tail_ill_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_ill_q <= 1'b0;
      tail_ill_q <= 1'b0;
    end else begin
      if (head_ld_in)        head_ill_q <= is_illegal(in_instr[6:0]);
      else if (head_ld_tail) head_ill_q <= tail_ill_q;
      if (tail_ld)           tail_ill_q <= is_illegal(in_instr[6:0]);
    end
  end

  assign out_illegal = head_ill_q;
`else
  assign out_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_imm_decode_buffer.sv
// Randomized + directed bench for imm_decode_buffer against a queue-based reference model.
module tb_imm_decode_buffer;
  localparam int PC_W = 32;

  logic            clk = 1'b0, rst = 1'b0;
  logic            in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic [31:0]     in_instr = '0;
  logic [PC_W-1:0] in_pc = '0;
  logic            in_ready, out_valid, out_illegal;
  logic [31:0]     out_instr;
  logic [PC_W-1:0] out_pc;
  logic [24:0]     out_imm_field;
  logic [2:0]      out_imm_src;

  imm_decode_buffer #(.PC_W(PC_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .out_imm_field(out_imm_field), .out_imm_src(out_imm_src),
    .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]     instr;
    logic [PC_W-1:0] pc;
  } ent_t;

  ent_t q[$];
  int   checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] exp_src(input logic [31:0] i);
    logic [6:0] op = i[6:0];
    if (op == 7'h03 || op == 7'h13 || op == 7'h67) return 3'd0;
    if (op == 7'h23) return 3'd1;
    if (op == 7'h63) return 3'd2;
    if (op == 7'h37 || op == 7'h17) return 3'd3;
    if (op == 7'h6f) return 3'd4;
    if (op == 7'h73) return 3'd5;
    return 3'd7;
  endfunction

  function automatic logic exp_ill(input logic [31:0] i);
`ifdef IMM_ILLEGAL_EN
    return (exp_src(i) == 3'd7) && (i[6:0] != 7'h33);
`else
    return 1'b0;
`endif
  endfunction

  task automatic check_out();
    chk("in_ready", {63'd0, in_ready}, {63'd0, q.size() < 2});
    chk("out_valid", {63'd0, out_valid}, {63'd0, q.size() > 0});
    if (q.size() > 0) begin
      chk("out_instr", {32'd0, out_instr}, {32'd0, q[0].instr});
      chk("out_pc", {{(64-PC_W){1'b0}}, out_pc}, {{(64-PC_W){1'b0}}, q[0].pc});
      chk("out_imm_field", {39'd0, out_imm_field}, {39'd0, q[0].instr[31:7]});
      chk("out_imm_src", {61'd0, out_imm_src}, {61'd0, exp_src(q[0].instr)});
      chk("out_illegal", {63'd0, out_illegal}, {63'd0, exp_ill(q[0].instr)});
    end
  endtask

  // one clock: check current outputs, drive inputs, advance the model at the edge
  task automatic step(input logic v, input logic [31:0] ins, input logic [PC_W-1:0] pc,
                      input logic ordy, input logic fl, output logic acc);
    int   sz;
    ent_t e;
    @(negedge clk);
    check_out();
    in_valid = v; in_instr = ins; in_pc = pc; out_ready = ordy; flush = fl;
    @(posedge clk);
    sz  = q.size();
    acc = v && sz < 2 && !fl;
    if (fl) q.delete();
    else begin
      if (sz > 0 && ordy) void'(q.pop_front());
      if (v && sz < 2) begin
        e.instr = ins; e.pc = pc;
        q.push_back(e);
      end
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [10] = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6f, 7'h73, 7'h33};
    logic [31:0] r = $urandom();
    int          k = $urandom_range(0, 12);
    logic [6:0]  op = (k < 10) ? ops[k] : r[6:0];
    return {r[31:7], op};
  endfunction

  initial begin
    logic        a;
    logic [31:0] r;
    logic [6:0]  stream_ops [6] = '{7'h03, 7'h23, 7'h63, 7'h37, 7'h6f, 7'h73};
    int          guard;

    // reset state
    #12;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_instr", {32'd0, out_instr}, 64'd0);
    chk("rst_field", {39'd0, out_imm_field}, 64'd0);
    chk("rst_src", {61'd0, out_imm_src}, 64'd7);
    chk("rst_illegal", {63'd0, out_illegal}, 64'd0);
    @(negedge clk); rst = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, 32'hdeadbeef, '0, 1'b1, 1'b0, a);

    // in-order stream, all select encodings
    for (int i = 0; i < 6; i++) begin
      r = $urandom();
      step(1'b1, {r[31:7], stream_ops[i]}, 32'h100 + 4*i, 1'b1, 1'b0, a);
    end
    for (int i = 0; i < 2; i++) step(1'b0, '0, '0, 1'b1, 1'b0, a);

    // back-pressure: three offered, two taken, third after first pop
    step(1'b1, rand_instr(), 32'h200, 1'b0, 1'b0, a);
    step(1'b1, rand_instr(), 32'h204, 1'b0, 1'b0, a);
    r = rand_instr();
    step(1'b1, r, 32'h208, 1'b0, 1'b0, a);
    guard = 0;
    do begin
      step(1'b1, r, 32'h208, 1'b1, 1'b0, a);
      guard++;
    end while (!a && guard < 10);
    chk("bp_accept_bound", {63'd0, guard < 10}, 64'd1);
    for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 1'b1, 1'b0, a);

    // flush in FULL with concurrent offer
    step(1'b1, rand_instr(), 32'h300, 1'b0, 1'b0, a);
    step(1'b1, rand_instr(), 32'h304, 1'b0, 1'b0, a);
    step(1'b1, rand_instr(), 32'h308, 1'b0, 1'b1, a);
    for (int i = 0; i < 2; i++) step(1'b0, '0, '0, 1'b1, 1'b0, a);

    // unrecognised opcode, then async reset while holding it in ONE
    step(1'b1, 32'h0000007f, 32'h400, 1'b0, 1'b0, a);
    step(1'b0, '0, '0, 1'b0, 1'b0, a);
    @(negedge clk);
    check_out();
    #2 rst = 1'b0;
    #1;
    chk("arst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("arst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("arst_instr", {32'd0, out_instr}, 64'd0);
    chk("arst_pc", {32'd0, out_pc}, 64'd0);
    chk("arst_src", {61'd0, out_imm_src}, 64'd7);
    chk("arst_illegal", {63'd0, out_illegal}, 64'd0);
    q.delete();
    @(negedge clk); rst = 1'b1;

    // randomized traffic
    for (int i = 0; i < 2000; i++)
      step(($urandom() % 4) != 0, rand_instr(), $urandom(), ($urandom() % 3) != 0,
           ($urandom() % 20) == 0, a);
    @(negedge clk);
    check_out();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/imm_decode_buffer.md
# imm_decode_buffer

Decode-stage front end for the immediate extender. It accepts fetched instructions through a valid/ready handshake and buffers them in a 2-entry skid buffer. For each instruction it computes the extender's 3-bit immediate-source select and the 25-bit immediate field, then presents instruction, PC, field and select to the decode/execute boundary in program order. It sequences the extender: the extender input changes only when a new instruction is presented.

## Interface
- `PC_W`, default 32: PC width in bits.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `in_valid` input 1: fetch offers `in_instr`/`in_pc`.
- `in_ready` output 1: buffer can accept. Registered; not combinationally dependent on `out_ready`.
- `in_instr` input 32: fetched instruction.
- `in_pc` input `PC_W`: PC of `in_instr`.
- `flush` input 1: synchronous kill of all buffered entries.
- `out_valid` output 1: head entry valid.
- `out_ready` input 1: consumer takes head entry.
- `out_instr` output 32: head instruction.
- `out_pc` output `PC_W`: head PC.
- `out_imm_field` output 25: head `instr[31:7]`, wired to the extender immediate input.
- `out_imm_src` output 3: extender select for the head entry.
- `out_illegal` output 1: head opcode unrecognised. Active only with `IMM_ILLEGAL_EN`.

## Operation
- Accept occurs on a cycle with `in_valid && in_ready`. Pop occurs on a cycle with `out_valid && out_ready`.
- Storage is 2 entries, FIFO order. Occupancy states:
  - EMPTY: accept → ONE.
  - ONE: accept without pop → FULL. Pop without accept → EMPTY. Accept and pop together → ONE.
  - FULL: pop → ONE. Accept is impossible because `in_ready` = 0.
- `in_ready` = 1 in EMPTY and ONE, 0 in FULL.
- Decode is performed at accept time and stored with the entry. It uses opcode = `instr[6:0]`:
  - `0000011` LOAD, `0010011` OP-IMM, `1100111` JALR → `000`
  - `0100011` STORE → `001`
  - `1100011` BRANCH → `010`
  - `0110111` LUI, `0010111` AUIPC → `011`
  - `1101111` JAL → `100`
  - `1110011` SYSTEM (CSR zimm) → `101`
  - `0110011` OP (no immediate) → `111`, so the extender outputs 0.
  - Any other opcode → `111`, and illegal = 1 when `IMM_ILLEGAL_EN` is defined.
- `flush` takes priority over everything:
  - Next state is EMPTY and all valid bits are cleared.
  - An accept in the flush cycle is discarded.
  - `in_ready` = 1 the following cycle.
- Data registers of empty slots hold their values. Outputs are don't-care while `out_valid` = 0; only reset forces them to 0.

## Timing
- Reset (`rst` low, asynchronous):
  - State EMPTY.
  - `in_ready` = 1, `out_valid` = 0.
  - `out_instr`, `out_pc`, `out_imm_field` = 0.
  - `out_imm_src` = `111`, `out_illegal` = 0.
- Reset asserted mid-transfer drops all entries immediately, with no partial outputs.
- Latency: an accept at edge N gives `out_valid` = 1 after edge N; the entry is visible in the cycle following the accept. There is no bypass from input to output in the same cycle.
- Throughput: 1 instruction per cycle while `out_ready` stays high.
- Back-pressure:
  - `out_ready` low for 2 cycles with continuous input fills the buffer; `in_ready` falls after the second accept.
  - The first pop re-raises `in_ready` on the next cycle.
- All outputs are driven from registers. The only combinational path is `out_*` to the extender.
- Output stability: while `out_valid` && !`out_ready`, every `out_*` stays constant.

## Configuration
- `IMM_ILLEGAL_EN` defined:
  - The opcode decode flags unrecognised opcodes; the flag is stored per entry and driven on `out_illegal`.
  - The entry still flows normally with `out_imm_src` = `111`.
- `IMM_ILLEGAL_EN` undefined:
  - `out_illegal` is tied to 0 and no illegal storage is built.
  - Unrecognised opcodes still map to `111`.

## Test plan
- Reset then idle: `out_valid` = 0, `in_ready` = 1, `out_imm_src` = `111`. Release reset → no spurious output.
- Stream opcodes `0000011`, `0100011`, `1100011`, `0110111`, `1101111`, `1110011` with `out_ready` = 1 → `out_imm_src` sequence `000`, `001`, `010`, `011`, `100`, `101`, one cycle after each accept. `out_imm_field` = `instr[31:7]`.
- Hold `out_ready` = 0 and push 3 instructions → only 2 accepted, `in_ready` = 0. Release `out_ready` → outputs drain in order, and the 3rd instruction is accepted one cycle after the first pop.
- In FULL, assert `flush` together with `in_valid` → next cycle `out_valid` = 0, `in_ready` = 1, and no flushed or concurrent entry appears.
- Instruction `0x0000007F` (opcode `1111111`) → `out_imm_src` = `111`. `out_illegal` = 1 with `IMM_ILLEGAL_EN`, 0 without.
- Assert `rst` while ONE with `out_ready` = 0 → `out_valid` drops asynchronously to 0 and outputs return to their reset values.
